// File: rtl/step_pulse_gen_if.sv
// step_pulse_gen_if: raw step inputs in,
// score counter pulses and status out.
interface step_pulse_gen_if;
  logic HIT_RAW;
  logic MISS_RAW;
  logic EN;
  logic UP;
  logic DOWN;
  logic BUSY;
  logic OVF;

  modport master (
    output HIT_RAW,
    output MISS_RAW,
    output EN,
    input  UP,
    input  DOWN,
    input  BUSY,
    input  OVF
  );

  modport slave (
    input  HIT_RAW,
    input  MISS_RAW,
    input  EN,
    output UP,
    output DOWN,
    output BUSY,
    output OVF
  );
endinterface

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: sync + debounce HIT/MISS,
// queue rising edges, emit spaced UP/DOWN pulses.
module step_pulse_gen #(
  parameter int DEBOUNCE = 4,
  parameter int PEND_MAX = 7
) (
  input logic             CLOCK,
  input logic             RESET,
  step_pulse_gen_if.slave bus
);

  localparam logic [3:0] DB_LAST =
    4'(DEBOUNCE - 1);
  localparam logic [2:0] PMAX =
    3'(PEND_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic       hit_s1;
  logic       hit_s2;
  logic       miss_s1;
  logic       miss_s2;

  logic       hit_stable;
  logic       hit_stable_d;
  logic [3:0] hit_cnt;
  logic       miss_stable;
  logic       miss_stable_d;
  logic [3:0] miss_cnt;

  logic       hit_evt;
  logic       miss_evt;

  logic [2:0] hit_pend;
  logic [2:0] miss_pend;

  state_t     state;
  logic       last_down;
  logic       up_q;
  logic       down_q;
  logic       busy_q;
  logic       ovf_q;

  logic       hit_nz;
  logic       miss_nz;
  logic       tie;
  logic       disp;
  logic       pick_hit;
  logic       hit_disp;
  logic       miss_disp;
  logic       hit_drop;
  logic       miss_drop;

  // two-flop synchronisers for the raw pads
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      hit_s1  <= 1'b0;
      hit_s2  <= 1'b0;
      miss_s1 <= 1'b0;
      miss_s2 <= 1'b0;
    end else begin
      hit_s1  <= bus.HIT_RAW;
      hit_s2  <= hit_s1;
      miss_s1 <= bus.MISS_RAW;
      miss_s2 <= miss_s1;
    end
  end

  // hit debouncer: flip only after a full run
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      hit_stable   <= 1'b0;
      hit_stable_d <= 1'b0;
      hit_cnt      <= 4'd0;
    end else begin
      hit_stable_d <= hit_stable;
      if (hit_s2 == hit_stable) begin
        hit_cnt <= 4'd0;
      end else if (hit_cnt == DB_LAST) begin
        hit_stable <= hit_s2;
        hit_cnt    <= 4'd0;
      end else begin
        hit_cnt <= hit_cnt + 4'd1;
      end
    end
  end

  // miss debouncer: same scheme as hit
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      miss_stable   <= 1'b0;
      miss_stable_d <= 1'b0;
      miss_cnt      <= 4'd0;
    end else begin
      miss_stable_d <= miss_stable;
      if (miss_s2 == miss_stable) begin
        miss_cnt <= 4'd0;
      end else if (miss_cnt == DB_LAST) begin
        miss_stable <= miss_s2;
        miss_cnt    <= 4'd0;
      end else begin
        miss_cnt <= miss_cnt + 4'd1;
      end
    end
  end

  // rising edges only; releases are ignored
  assign hit_evt  = hit_stable & ~hit_stable_d;
  assign miss_evt = miss_stable & ~miss_stable_d;

  // dispatch decision, only taken from IDLE
  always_comb begin
    hit_nz   = (hit_pend != 3'd0);
    miss_nz  = (miss_pend != 3'd0);
    tie      = hit_nz & miss_nz;
    disp     = (state == IDLE) & bus.EN &
               (hit_nz | miss_nz);
    pick_hit = hit_nz & (~miss_nz | last_down);
    hit_disp  = disp & pick_hit;
    miss_disp = disp & ~pick_hit;
    hit_drop  = hit_evt & ~hit_disp &
                (hit_pend == PMAX);
    miss_drop = miss_evt & ~miss_disp &
                (miss_pend == PMAX);
  end

  // saturating pending counters + sticky overflow
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      hit_pend  <= 3'd0;
      miss_pend <= 3'd0;
      ovf_q     <= 1'b0;
    end else begin
      if (hit_evt & ~hit_disp & ~hit_drop)
        hit_pend <= hit_pend + 3'd1;
      else if (hit_disp & ~hit_evt)
        hit_pend <= hit_pend - 3'd1;
      if (miss_evt & ~miss_disp & ~miss_drop)
        miss_pend <= miss_pend + 3'd1;
      else if (miss_disp & ~miss_evt)
        miss_pend <= miss_pend - 3'd1;
      if (hit_drop | miss_drop)
        ovf_q <= 1'b1;
    end
  end

  // emitter FSM; tie history only moves on
  // contested picks, so a lone event does not
  // steal the next tie from the other side
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state     <= IDLE;
      last_down <= 1'b1;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          up_q   <= 1'b0;
          down_q <= 1'b0;
          if (disp) begin
            state  <= PULSE;
            up_q   <= pick_hit;
            down_q <= ~pick_hit;
            if (tie)
              last_down <= ~pick_hit;
          end
        end
        PULSE: begin
          up_q   <= 1'b0;
          down_q <= 1'b0;
          state  <= GAP;
        end
        GAP: begin
          up_q   <= 1'b0;
          down_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          up_q   <= 1'b0;
          down_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // busy lags the state/pending view by a cycle
  always_ff @(posedge CLOCK) begin
    if (!RESET)
      busy_q <= 1'b0;
    else
      busy_q <= (state != IDLE) | hit_nz | miss_nz;
  end

  assign bus.UP   = up_q;
  assign bus.DOWN = down_q;
  assign bus.BUSY = busy_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Front end of the score path: turns raw HIT/MISS step-judgement signals from the arrow-pad logic into clean single-cycle UP/DOWN pulses for the decimal score counter. It synchronises and debounces each raw input and queues rising-edge events in saturating pending counters. It then emits pulses one at a time, spaced so the counter's IDLE→INC/DEC→IDLE FSM is always back in IDLE before the next pulse.

## Interface
- DEBOUNCE, 4: consecutive synchronised cycles an input must differ from its stable value before the stable value flips (range 1–15).
- PEND_MAX, 7: saturation value of each pending-event counter (3-bit counters).
- CLOCK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- HIT_RAW  in  1  raw step-hit input, asynchronous, may bounce.
- MISS_RAW  in  1  raw step-miss input, asynchronous, may bounce.
- EN  in  1  emit enable; low blocks new pulses while events still accumulate (pause screen).
- UP  out  1  one-cycle increment pulse to score counter.
- DOWN  out  1  one-cycle decrement pulse to score counter.
- BUSY  out  1  high when FSM not IDLE or any pending count nonzero.
- OVF  out  1  sticky: an event was dropped at saturation; cleared only by reset.

## Operation
- Per input: 2-flop synchroniser (s1→s2), then debouncer with stable register, 4-bit counter, and registered stable_d.
- Debounce: s2 == stable → counter cleared. s2 != stable with counter < DEBOUNCE-1 → counter+1. s2 != stable with counter == DEBOUNCE-1 → stable <= s2, counter cleared.
- Event = stable & ~stable_d (rising edge only; falling edges ignored).
- Pending counters hit_pend, miss_pend, 3-bit:
  - event only: +1;
  - dispatch only: −1;
  - event and dispatch same cycle: unchanged;
  - event at PEND_MAX without dispatch: count held, event dropped, OVF <= 1.
- Emitter FSM, states IDLE, PULSE, GAP:
  - IDLE: if EN and (hit_pend or miss_pend nonzero), dispatch → PULSE. Otherwise stay.
  - PULSE: drive selected output high for exactly this cycle, → GAP.
  - GAP: all outputs low, → IDLE.
- Selection in IDLE: only one nonzero → that one. Both nonzero → round-robin against last_served (UP for hit, DOWN for miss).
- UP and DOWN are registered, decoded from state plus a latched select bit. Never both high.
- EN sampled only in IDLE. Deasserting EN during PULSE or GAP does not truncate the current pulse.
- Reset (RESET == 0 at an edge) forces the following values after that edge, including mid-PULSE (pulse dropped):
  - synchronisers, stable, stable_d and debounce counters = 0;
  - pending counters = 0;
  - state = IDLE;
  - last_served = DOWN, so UP wins the first tie;
  - UP = DOWN = BUSY = OVF = 0.

## Timing
- Raw input first sampled high at edge 1 (edges counted from there):
  - s2 high after edge 2;
  - stable high after edge 2+DEBOUNCE;
  - pending increments at edge 3+DEBOUNCE;
  - FSM enters PULSE at edge 4+DEBOUNCE.
- Latency, DEBOUNCE=4: UP/DOWN high for the single cycle after edge 8.
- Minimum pulse spacing: 3 cycles (PULSE, GAP, IDLE). Maximum emission rate: one pulse per 3 cycles.
- A raw level lasting fewer than DEBOUNCE synchronised cycles produces no event.
- BUSY is registered: it rises the cycle after the first pending increment and falls the cycle after the FSM returns to IDLE with both counts zero.

## Test plan
- Reset: hold RESET=0 for 2 edges with HIT_RAW=MISS_RAW=1 → UP=DOWN=BUSY=OVF=0, and no pulse until DEBOUNCE+4 edges after release.
- Single hit: HIT_RAW high 20 cycles, EN=1, DEBOUNCE=4 → exactly one UP pulse, one cycle wide, after edge 8; DOWN stays 0.
- Glitch reject: HIT_RAW high 3 cycles then low → no UP, pending stays 0, BUSY stays 0.
- Tie: HIT_RAW and MISS_RAW rise in the same cycle → UP after edge 8, DOWN after edge 11; then swap priority check: next simultaneous pair yields DOWN first.
- Overflow: EN=0, 9 debounced hit presses (each 6 high / 6 low) → hit_pend=7, OVF=1. Then EN=1 → exactly 7 UP pulses 3 cycles apart, then BUSY=0 with OVF still 1.
- Mid-pulse reset: assert RESET=0 at the edge entering PULSE with hit_pend=3 → UP low next cycle, pending=0, no further pulses.
